// File: rtl/cpu_bus_pkg.sv
// Shared CPU-side bus definitions: master IDs, arbiter states, access sizes.
package cpu_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [0:0] {
        MID_INST = 1'b0,
        MID_DATA = 1'b1
    } master_id_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } arb_state_t;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order tracker of outstanding transaction owners (master IDs).
module id_fifo
    import cpu_bus_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  master_id_t       push_id,
    input  logic             pop,
    output master_id_t       head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    master_id_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    // Advance a pointer with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // ID storage; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_id;
    end

    assign head = mem_q[rd_ptr_q];
    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) arbiter onto one SRAM-like port, data has priority;
// the grant is held until the address handshake, responses are routed in order.
module sram_like_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t       state_q, state_d;
    logic             grant_valid;
    master_id_t       grant_id;
    logic             push, pop;
    master_id_t       head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             orphan_q;

    id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (grant_id),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count),
        .full    (fifo_full)
    );

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grant selection, memory-port mux, handshakes and next state.
    always_comb begin
        state_d      = state_q;
        grant_valid  = 1'b0;
        grant_id     = MID_INST;
        mem_req      = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Full is judged on the registered count; a same-cycle pop does not help.
                if (!fifo_full) begin
                    if (data_req) begin
                        grant_valid = 1'b1;
                        grant_id    = MID_DATA;
                    end else if (inst_req) begin
                        grant_valid = 1'b1;
                    end
                end
            end
            LOCK_INST: grant_valid = 1'b1;
            LOCK_DATA: begin
                grant_valid = 1'b1;
                grant_id    = MID_DATA;
            end
            default: state_d = IDLE;
        endcase

        mem_wr    = (grant_id == MID_DATA) ? data_wr    : inst_wr;
        mem_size  = (grant_id == MID_DATA) ? data_size  : inst_size;
        mem_addr  = (grant_id == MID_DATA) ? data_addr  : inst_addr;
        mem_wdata = (grant_id == MID_DATA) ? data_wdata : inst_wdata;
        mem_req   = !rst && grant_valid &&
                    ((grant_id == MID_DATA) ? data_req : inst_req);

        push = mem_req && mem_addr_ok;
        if (mem_req) begin
            if (mem_addr_ok)               state_d = IDLE;
            else if (grant_id == MID_DATA) state_d = LOCK_DATA;
            else                           state_d = LOCK_INST;
        end
        inst_addr_ok = push && (grant_id == MID_INST);
        data_addr_ok = push && (grant_id == MID_DATA);

        pop          = !rst && mem_data_ok && (fifo_count != '0);
        inst_data_ok = pop && (head == MID_INST);
        data_data_ok = pop && (head == MID_DATA);
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // Responses still in flight across a reset are tolerated until new traffic starts.
    always_ff @(posedge clk) begin
        if (rst)       orphan_q <= 1'b1;
        else if (push) orphan_q <= 1'b0;
    end

    // Protocol checks on the slave and master sides.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_data_ok && fifo_count == '0 && !orphan_q))
                else $error("sram_like_arbiter: mem_data_ok with nothing outstanding");
            assert (!(state_q == LOCK_INST && !inst_req))
                else $error("sram_like_arbiter: inst_req dropped while locked");
            assert (!(state_q == LOCK_DATA && !data_req))
                else $error("sram_like_arbiter: data_req dropped while locked");
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with MAX_OUTSTANDING = 2.
module tb_sram_like_arbiter;
    import cpu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = SZ_WORD; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    initial begin
        // ---- reset: outputs gated even with live requests/handshakes ----
        clear_inputs();
        rst = 1;
        inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        rst = 0; clear_inputs();
        settle();
        chk("rst_count", 32'(dut.fifo_count), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        tick();

        // ---- single inst read ----
        inst_req = 1; inst_addr = 32'h1FC0_0000; mem_addr_ok = 1;
        settle();
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h1FC0_0000);
        chk("t1_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        settle();
        chk("t1_count1", 32'(dut.fifo_count), 32'd1);
        chk("t1_idle_req", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h3C08_0001;
        settle();
        chk("t1_data_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
        chk("t1_rdata", inst_rdata, 32'h3C08_0001);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t1_count0", 32'(dut.fifo_count), 32'd0);

        // ---- simultaneous requests: data first, then inst ----
        inst_req = 1; inst_addr = 32'h1FC0_0004;
        data_req = 1; data_wr = 1; data_addr = 32'h0000_0010; data_wdata = 32'hDEAD_BEEF;
        mem_addr_ok = 1;
        settle();
        chk("t2_mem_addr", mem_addr, 32'h0000_0010);
        chk("t2_mem_wr", 32'(mem_wr), 32'd1);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_addr_ok_d", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
        tick();
        data_req = 0; data_wr = 0;
        settle();
        chk("t2_mem_addr_i", mem_addr, 32'h1FC0_0004);
        chk("t2_mem_wr_i", 32'(mem_wr), 32'd0);
        chk("t2_addr_ok_i", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFE_0001;
        settle();
        chk("t2_count2", 32'(dut.fifo_count), 32'd2);
        chk("t2_resp_d", 32'({inst_data_ok, data_data_ok}), 32'b01);
        chk("t2_rdata_d", data_rdata, 32'hCAFE_0001);
        tick();
        mem_rdata = 32'h1234_5678;
        settle();
        chk("t2_resp_i", 32'({inst_data_ok, data_data_ok}), 32'b10);
        chk("t2_rdata_i", inst_rdata, 32'h1234_5678);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t2_count0", 32'(dut.fifo_count), 32'd0);

        // ---- lock hold: inst locked, data cannot pre-empt ----
        inst_req = 1; inst_addr = 32'h1FC0_0008;
        settle();
        chk("t3_c0_req", 32'(mem_req), 32'd1);
        chk("t3_c0_addr_ok", 32'(inst_addr_ok), 32'd0);
        tick();
        data_req = 1; data_addr = 32'h0000_0020; data_size = SZ_BYTE;
        settle();
        chk("t3_c1_state", 32'(dut.state_q), 32'(LOCK_INST));
        chk("t3_c1_addr", mem_addr, 32'h1FC0_0008);
        chk("t3_c1_aok", 32'({inst_addr_ok, data_addr_ok}), 32'b00);
        tick();
        settle();
        chk("t3_c2_addr", mem_addr, 32'h1FC0_0008);
        tick();
        mem_addr_ok = 1;
        settle();
        chk("t3_c3_addr", mem_addr, 32'h1FC0_0008);
        chk("t3_c3_aok", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
        tick();
        inst_req = 0;
        settle();
        chk("t3_c4_addr", mem_addr, 32'h0000_0020);
        chk("t3_c4_size", 32'(mem_size), 32'(SZ_BYTE));
        chk("t3_c4_aok", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
        tick();
        data_req = 0; data_size = SZ_WORD; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("t3_resp_i", 32'({inst_data_ok, data_data_ok}), 32'b10);
        tick();
        settle();
        chk("t3_resp_d", 32'({inst_data_ok, data_data_ok}), 32'b01);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t3_count0", 32'(dut.fifo_count), 32'd0);

        // ---- full back-pressure and pop-does-not-free-slot rule ----
        inst_req = 1; inst_addr = 32'h1FC0_0100; mem_addr_ok = 1;
        tick();
        inst_addr = 32'h1FC0_0104;
        settle();
        chk("t4_second_aok", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_addr = 32'h1FC0_0108;
        settle();
        chk("t4_full_count", 32'(dut.fifo_count), 32'd2);
        chk("t4_full_req", 32'(mem_req), 32'd0);
        chk("t4_full_aok", 32'(inst_addr_ok), 32'd0);
        tick();
        mem_data_ok = 1;
        settle();
        chk("t4_pop_resp", 32'(inst_data_ok), 32'd1);
        chk("t4_pop_req", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t4_after_req", 32'(mem_req), 32'd1);
        chk("t4_after_aok", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_req = 0; mem_addr_ok = 0;

        // ---- push+pop coincidence at count = 1 ----
        mem_data_ok = 1;
        settle();
        chk("t5_drain_resp", 32'(inst_data_ok), 32'd1);
        tick();
        data_req = 1; data_addr = 32'h0000_0030; mem_addr_ok = 1; mem_data_ok = 1;
        settle();
        chk("t5_pp_count", 32'(dut.fifo_count), 32'd1);
        chk("t5_pp_aok", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
        chk("t5_pp_resp", 32'({inst_data_ok, data_data_ok}), 32'b10);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        settle();
        chk("t5_count_hold", 32'(dut.fifo_count), 32'd1);
        tick();
        mem_data_ok = 1;
        settle();
        chk("t5_new_head", 32'({inst_data_ok, data_data_ok}), 32'b01);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t5_count0", 32'(dut.fifo_count), 32'd0);

        // ---- reset mid-flight drops tracking ----
        inst_req = 1; inst_addr = 32'h1FC0_0200; mem_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_0040;
        tick();
        data_req = 0; mem_addr_ok = 0;
        settle();
        chk("t6_count2", 32'(dut.fifo_count), 32'd2);
        rst = 1;
        tick();
        rst = 0; mem_data_ok = 1; mem_rdata = 32'hBAD0_BAD0;
        settle();
        chk("t6_no_resp", 32'({inst_data_ok, data_data_ok}), 32'b00);
        chk("t6_count0", 32'(dut.fifo_count), 32'd0);
        chk("t6_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        mem_data_ok = 0;
        settle();
        chk("t6_count_stay0", 32'(dut.fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) between two masters: the fetch stage (inst_*) and the memory stage (data_*).
- Fixed priority, data over inst.
- Holds the grant until the address handshake completes.
- Tracks outstanding transactions in a master-ID FIFO and routes each in-order data_ok/rdata back to the master that issued it.
- Sits between the CPU core and the cache/AXI bridge.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..8); sets the ID FIFO depth.

Ports:
clk  in  1  clock
rst  in  1  reset
inst_req / data_req  in  1  master request; held until its addr_ok
inst_wr / data_wr  in  1  1 = write
inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
inst_addr / data_addr  in  32  physical address
inst_wdata / data_wdata  in  32  write data
inst_addr_ok / data_addr_ok  out  1  address accepted for this master
inst_data_ok / data_data_ok  out  1  response for this master
inst_rdata / data_rdata  out  32  read data; a copy of mem_rdata
mem_req  out  1  request to slave
mem_wr  out  1  write to slave
mem_size  out  2  size to slave
mem_addr  out  32  address to slave
mem_wdata  out  32  write data to slave
mem_addr_ok  in  1  slave accepted address
mem_data_ok  in  1  slave response (in order)
mem_rdata  in  32  slave read data

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Effect: state IDLE, FIFO count = 0, head/tail pointers = 0.
  - Outputs under reset: mem_req = 0, all *_addr_ok = 0, all *_data_ok = 0.
  - Reset mid-transaction drops all tracking. mem_data_ok arriving after reset with count = 0 is ignored.
- full = (count == MAX_OUTSTANDING).
- Lock FSM, states IDLE, LOCK_INST, LOCK_DATA:
  - IDLE, full: mem_req = 0; no master sees addr_ok.
  - IDLE, not full: grant data if data_req, else inst if inst_req, else none.
    - mem_* mirrors the granted master combinationally; mem_req = granted master's req.
    - If mem_addr_ok arrives in the same cycle: push the granted ID and stay IDLE.
    - Otherwise go to LOCK_<granted>.
  - LOCK_x: mem_* mirrors master x regardless of the other request; mem_req = x_req.
    - On mem_addr_ok: push x and return to IDLE.
    - A higher-priority request cannot pre-empt a lock.
- x_addr_ok = mem_addr_ok && mem_req && (granted master == x). At most one master sees addr_ok per cycle.
- Response routing: head = FIFO[rd_ptr].
  - x_data_ok = mem_data_ok && count != 0 && head == x.
  - On mem_data_ok with count != 0: pop.
  - inst_rdata = data_rdata = mem_rdata unconditionally.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A pop in the current cycle does not free a slot for a grant in the same cycle: full is evaluated on registered count.
- Pointers wrap modulo MAX_OUTSTANDING. count width = $clog2(MAX_OUTSTANDING+1).
- Latency: zero-cycle combinational path from master to mem_* and from mem_addr_ok/mem_data_ok to the master handshakes. Responses arrive no earlier than the cycle after addr_ok.
- Errors:
  - mem_data_ok with count = 0 is an assertion failure (simulation only); it is otherwise ignored.
  - A master dropping req while locked is an assertion failure.

Decomposition:
- Shared package cpu_bus_pkg:
  - typedef master_id_t enum {MID_INST = 0, MID_DATA = 1}
  - typedef arb_state_t {IDLE, LOCK_INST, LOCK_DATA}
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2
- One sub-module: id_fifo, a parameterised synchronous FIFO of master_id_t with push, pop, head, count and full outputs. It is reused later for the AXI bridge.

Test Plan:
- Single inst read: inst_req = 1, addr 0x1FC00000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata 0x3C080001 -> inst_addr_ok at cycle 0, inst_data_ok + inst_rdata = 0x3C080001 at cycle 2, count returns to 0.
- Simultaneous requests: inst_req and data_req (data sw 0x00000010, wdata 0xDEADBEEF) in the same cycle -> mem_addr = 0x10, mem_wr = 1, data_addr_ok first. Inst is granted the next cycle. Responses arrive in order: data_data_ok, then inst_data_ok.
- Lock hold: inst_req, mem_addr_ok held low 3 cycles, data_req rises in cycle 1 -> mem_addr stays the inst address until addr_ok in cycle 3. Data is granted in cycle 4.
- Full back-pressure, MAX_OUTSTANDING = 2: two accepted reads, no data_ok -> mem_req = 0 on the third request. Check the same-cycle rule: on the first data_ok, mem_req stays 0 that cycle and rises the next cycle.
- Push+pop coincidence: count = 1, new addr_ok and data_ok in the same cycle -> count stays 1, the response goes to the old head's master, and the new ID sits at head next.
- Reset mid-flight: count = 2, assert rst one cycle, then mem_data_ok pulse -> no *_data_ok is asserted, count = 0, state IDLE.
